// File: rtl/conv_pkg.sv
// Shared types and helpers for the multi-channel convolution front end.
package conv_pkg;

    localparam int unsigned FP16_SIGN_BIT = 15;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } conv_state_e;

    // Clamp anything with the sign bit set (including -0 and negative NaN) to +0.
    function automatic fp16_t fp16_relu(input fp16_t x);
        return x[FP16_SIGN_BIT] ? 16'h0000 : x;
    endfunction

endpackage

// File: rtl/conv_if.sv
// Column stream from the convolution front end to the pooling/dense stage.
interface conv_if #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned OUT_COL_SIZE = 24,
    parameter int unsigned DATA_WIDTH   = 16
);
    localparam int unsigned IDX_W = (OUT_COL_SIZE > 1) ? $clog2(OUT_COL_SIZE) : 1;

    logic [NUM_CHANNELS-1:0][OUT_COL_SIZE-1:0][DATA_WIDTH-1:0] out_data;
    logic                                                       out_valid;
    logic                                                       out_ready;
    logic [IDX_W-1:0]                                           out_col_idx;
    logic                                                       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_col_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_col_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/conv_col_fifo.sv
// Synchronous column FIFO. A push while full is accepted only if a pop happens in the
// same cycle; otherwise it is dropped and flagged. Read data reads as zero when empty.
module conv_col_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             dropped
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Storage write; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_detection_test.sv
// Single-channel convolution engine. Produces IMAGE_SIZE-KERNEL_SIZE+1 output columns;
// each column costs one BRAM word (address = column index, one-cycle read latency) and
// row r of the column takes word element (r mod elements-per-word). done pulses the
// cycle after the last column's valid.
module edge_detection_test #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned KERNEL_SIZE  = 5,
    parameter int unsigned IMAGE_SIZE   = 28,
    parameter int unsigned OUT_COL_SIZE = 24,
    parameter int unsigned BRAM_WIDTH   = 256,
    parameter int unsigned ADDR_WIDTH   = 12
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [BRAM_WIDTH-1:0]                  bram_data,
    output logic [ADDR_WIDTH-1:0]                  bram_addr,
    output logic [OUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col_out,
    output logic                                   valid_out_col,
    output logic                                   done
);
    localparam int unsigned NUM_COLS = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int unsigned CW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned EPW      = BRAM_WIDTH / DATA_WIDTH;

    logic                                    run_q, phase_q, valid_q, last_q, done_q;
    logic [CW-1:0]                           col_q;
    logic [OUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col_q_data, word_col;

    assign bram_addr     = ADDR_WIDTH'(col_q);
    assign col_out       = col_q_data;
    assign valid_out_col = valid_q;
    assign done          = done_q;

    // Spread the current BRAM word across the column rows.
    always_comb begin
        word_col = '0;
        for (int r = 0; r < OUT_COL_SIZE; r++) begin
            word_col[r] = bram_data[(r % EPW) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Two-phase per column: present address, then capture the returned word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q      <= 1'b0;
            phase_q    <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            col_q      <= '0;
            col_q_data <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= valid_q & last_q;
            if (start && !run_q) begin
                run_q   <= 1'b1;
                phase_q <= 1'b0;
                col_q   <= '0;
            end else if (run_q) begin
                if (!phase_q) begin
                    phase_q <= 1'b1;
                end else begin
                    phase_q    <= 1'b0;
                    valid_q    <= 1'b1;
                    col_q_data <= word_col;
                    last_q     <= (col_q == CW'(NUM_COLS - 1));
                    if (col_q == CW'(NUM_COLS - 1)) begin
                        run_q <= 1'b0;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_multi_channel_top.sv
// N-channel convolution front end: lockstep engines on a shared BRAM stream, column
// alignment into a FIFO, and a valid/ready drain to the next stage.
module conv_multi_channel_top
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned KERNEL_SIZE  = 5,
    parameter int unsigned IMAGE_SIZE   = 28,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned OUT_COL_SIZE = 24,
    parameter int unsigned BRAM_WIDTH   = 256,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_CHANNELS-1:0] ch_enable,
    input  logic                    relu_en,
    input  logic [BRAM_WIDTH-1:0]   bram_data,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    conv_if.master                  out_if,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic                    sync_err
);
    localparam int unsigned IDX_W     = (OUT_COL_SIZE > 1) ? $clog2(OUT_COL_SIZE) : 1;
    localparam int unsigned DATA_BITS = NUM_CHANNELS * OUT_COL_SIZE * DATA_WIDTH;
    localparam int unsigned ENTRY_W   = DATA_BITS + IDX_W;

    typedef logic [NUM_CHANNELS-1:0][OUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col_set_t;

    conv_state_e              state_q, state_d;
    logic                     go;
    logic [NUM_CHANNELS-1:0]  ch_en_q, ch_active, done_seen_q;
    logic                     relu_q, overflow_q, sync_err_q, all_done, lockstep_err;
    logic [IDX_W-1:0]         col_cnt_q;

    logic                     eng_reset;
    logic [NUM_CHANNELS-1:0]  eng_start, eng_valid, eng_done;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] eng_addr;
    col_set_t                 eng_col, push_cols, head_cols;

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_dropped;
    logic [ENTRY_W-1:0]       fifo_rdata;
    logic [IDX_W-1:0]         head_idx;

    assign eng_reset = ~rst;
    // Engine 0 always runs since it owns the BRAM address.
    assign eng_start = {NUM_CHANNELS{go}} & (ch_enable | NUM_CHANNELS'(1));
    assign ch_active = ch_en_q | NUM_CHANNELS'(1);
    assign all_done  = &(done_seen_q | ~ch_active);
    assign bram_addr = eng_addr[0];

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_eng
        edge_detection_test #(
            .DATA_WIDTH  (DATA_WIDTH),
            .KERNEL_SIZE (KERNEL_SIZE),
            .IMAGE_SIZE  (IMAGE_SIZE),
            .OUT_COL_SIZE(OUT_COL_SIZE),
            .BRAM_WIDTH  (BRAM_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH)
        ) u_eng (
            .clk          (clk),
            .reset        (eng_reset),
            .start        (eng_start[g]),
            .bram_data    (bram_data),
            .bram_addr    (eng_addr[g]),
            .col_out      (eng_col[g]),
            .valid_out_col(eng_valid[g]),
            .done         (eng_done[g])
        );
    end

    if (NUM_CHANNELS > 1) begin : g_unused
        logic unused_addr;
        assign unused_addr = ^eng_addr[NUM_CHANNELS-1:1];
    end

    // Mask disabled channels to zero and apply optional ReLU before buffering.
    always_comb begin
        fp16_t elem;
        elem      = '0;
        push_cols = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            for (int r = 0; r < OUT_COL_SIZE; r++) begin
                elem = ch_active[ch] ? eng_col[ch][r] : '0;
                push_cols[ch][r] = relu_q ? fp16_relu(elem) : elem;
            end
        end
    end

    // Any enabled follower whose valid/done disagrees with engine 0 breaks lockstep.
    always_comb begin
        lockstep_err = 1'b0;
        for (int ch = 1; ch < NUM_CHANNELS; ch++) begin
            if (ch_en_q[ch] &&
                ((eng_valid[ch] != eng_valid[0]) || (eng_done[ch] != eng_done[0]))) begin
                lockstep_err = 1'b1;
            end
        end
    end

    assign fifo_push = (state_q == StRun) & eng_valid[0];
    assign fifo_pop  = ~fifo_empty & out_if.out_ready;

    conv_col_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data({col_cnt_q, push_cols}),
        .pop      (fifo_pop),
        .pop_data (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .dropped  (fifo_dropped)
    );

    assign head_cols = fifo_rdata[DATA_BITS-1:0];
    assign head_idx  = fifo_rdata[ENTRY_W-1 -: IDX_W];

    assign out_if.out_data    = head_cols;
    assign out_if.out_valid   = ~fifo_empty;
    assign out_if.out_col_idx = head_idx;
    assign out_if.out_last    = ~fifo_empty & (head_idx == IDX_W'(OUT_COL_SIZE - 1));

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign overflow = overflow_q;
    assign sync_err = sync_err_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in idle.
    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    go      = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (all_done) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Per-image configuration, column counter and sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_en_q     <= '0;
            relu_q      <= 1'b0;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            done_seen_q <= '0;
            col_cnt_q   <= '0;
        end else if (go) begin
            ch_en_q     <= ch_enable;
            relu_q      <= relu_en;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            done_seen_q <= '0;
            col_cnt_q   <= '0;
        end else if (state_q == StRun) begin
            // Counter advances even when the column is dropped.
            if (eng_valid[0]) begin
                if (col_cnt_q == IDX_W'(OUT_COL_SIZE - 1)) begin
                    col_cnt_q <= '0;
                end else begin
                    col_cnt_q <= col_cnt_q + 1'b1;
                end
            end
            done_seen_q <= done_seen_q | eng_done;
            if (fifo_dropped) begin
                overflow_q <= 1'b1;
            end
            if (lockstep_err) begin
                sync_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_multi_channel_top.sv
// Scoreboard bench for conv_multi_channel_top: expected columns are queued at start,
// a negedge monitor pops and compares on every accepted output column.
module tb_conv_multi_channel_top;
    import conv_pkg::*;

    localparam int NCH   = 4;
    localparam int COLS  = 24;
    localparam int DW    = 16;
    localparam int BW    = 256;
    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int EPW   = BW / DW;

    typedef logic [NCH-1:0][COLS-1:0][DW-1:0] col_t;
    typedef struct {
        col_t data;
        int   idx;
    } exp_t;

    logic           clk       = 1'b0;
    logic           rst       = 1'b1;
    logic           start     = 1'b0;
    logic           relu_en   = 1'b0;
    logic [NCH-1:0] ch_enable = '0;
    logic [BW-1:0]  bram_data = '0;
    logic [AW-1:0]  bram_addr;
    logic           busy, done, overflow, sync_err;

    conv_if #(.NUM_CHANNELS(NCH), .OUT_COL_SIZE(COLS), .DATA_WIDTH(DW)) out_if ();

    logic [BW-1:0] mem [COLS];
    exp_t          exp_q [$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            done_cnt = 0;
    int            start_cnt [NCH];

    conv_multi_channel_top #(
        .DATA_WIDTH  (DW),
        .KERNEL_SIZE (5),
        .IMAGE_SIZE  (28),
        .NUM_CHANNELS(NCH),
        .OUT_COL_SIZE(COLS),
        .BRAM_WIDTH  (BW),
        .ADDR_WIDTH  (AW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ch_enable(ch_enable),
        .relu_en  (relu_en),
        .bram_data(bram_data),
        .bram_addr(bram_addr),
        .out_if   (out_if),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    // BRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (int'(bram_addr) < COLS) bram_data <= mem[bram_addr[4:0]];
        else                        bram_data <= '0;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_col(input string name, input col_t act, input col_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            for (int ch = 0; ch < NCH; ch++) begin
                for (int r = 0; r < COLS; r++) begin
                    if (act[ch][r] !== exp[ch][r]) begin
                        $display("FAIL %s: ch %0d row %0d got %h, required %h",
                                 name, ch, r, act[ch][r], exp[ch][r]);
                        return;
                    end
                end
            end
        end
    endtask

    // Reference: row r of each enabled channel is word element r mod EPW, then ReLU.
    function automatic col_t model_col(input logic [BW-1:0] word, input logic [NCH-1:0] en,
                                       input bit relu);
        col_t        c;
        logic [15:0] e;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int r = 0; r < COLS; r++) begin
                e = word[(r % EPW) * DW +: DW];
                if (ch != 0 && !en[ch]) e = 16'h0000;
                if (relu && e[15]) e = 16'h0000;
                c[ch][r] = e;
            end
        end
        return c;
    endfunction

    task automatic expect_cols(input int n, input logic [NCH-1:0] en, input bit relu);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.data = model_col(mem[c], en, relu);
            e.idx  = c;
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_ramp();
        for (int c = 0; c < COLS; c++)
            for (int e = 0; e < EPW; e++) mem[c][e*DW +: DW] = 16'(c * EPW + e);
    endtask

    task automatic fill_random();
        for (int c = 0; c < COLS; c++)
            for (int e = 0; e < EPW; e++) mem[c][e*DW +: DW] = 16'($urandom());
    endtask

    task automatic fill_relu_mix();
        logic [15:0] vals [3];
        vals[0] = 16'hBC00;
        vals[1] = 16'h8000;
        vals[2] = 16'h3C00;
        for (int c = 0; c < COLS; c++)
            for (int e = 0; e < EPW; e++) mem[c][e*DW +: DW] = vals[(c + e) % 3];
    endtask

    task automatic pulse_start(input logic [NCH-1:0] en, input bit relu);
        @(posedge clk); #1;
        ch_enable = en;
        relu_en   = relu;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // mode 1 randomises out_ready but keeps it high every other cycle.
    task automatic wait_done(input int bound, input int mode, input int poke_at);
        int d0  = done_cnt;
        int cyc = 0;
        while (done_cnt == d0 && cyc < bound) begin
            if (mode == 1) out_if.out_ready = (cyc % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            start = (cyc == poke_at);
            if (cyc == poke_at) begin
                ch_enable = ~ch_enable;
                relu_en   = ~relu_en;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        out_if.out_ready = 1'b1;
        if (done_cnt == d0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done in %0d cycles, required a pulse", bound);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_col({tag, "_out_data"}, out_if.out_data, '0);
        chk({tag, "_out_valid"}, out_if.out_valid, 0);
        chk({tag, "_out_col_idx"}, out_if.out_col_idx, 0);
        chk({tag, "_out_last"}, out_if.out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_sync_err"}, sync_err, 0);
        chk({tag, "_bram_addr"}, bram_addr, 0);
    endtask

    // Output monitor and event counters.
    always @(negedge clk) begin
        if (rst) begin
            if (out_if.out_valid && out_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_col: got idx %0d, required no column",
                             out_if.out_col_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk_col("col_data", out_if.out_data, e.data);
                    chk("col_idx", out_if.out_col_idx, e.idx);
                    chk("col_last", out_if.out_last, (e.idx == COLS - 1));
                end
            end
            if (done) done_cnt++;
            for (int ch = 0; ch < NCH; ch++) if (dut.eng_start[ch]) start_cnt[ch]++;
        end
    end

    initial begin
        int          cyc;
        int          s0 [NCH];
        col_t        snap;
        bit          have_snap;
        logic [NCH-1:0] en;
        bit          relu;

        for (int ch = 0; ch < NCH; ch++) start_cnt[ch] = 0;
        for (int c = 0; c < COLS; c++) mem[c] = '0;
        out_if.out_ready = 1'b1;

        #1 rst = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;

        // Reset in the middle of an image, then a clean restart.
        fill_ramp();
        expect_cols(COLS, 4'b1111, 0);
        pulse_start(4'b1111, 0);
        cyc = 0;
        while (bram_addr != 11 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_col10", bram_addr, 11);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        expect_cols(COLS, 4'b1111, 0);
        pulse_start(4'b1111, 0);
        wait_done(200, 0, -1);

        // Ramp image, all channels, no ReLU.
        fill_ramp();
        expect_cols(COLS, 4'b1111, 0);
        pulse_start(4'b1111, 0);
        wait_done(200, 0, -1);
        chk("ramp_overflow", overflow, 0);
        chk("ramp_sync_err", sync_err, 0);

        // ReLU on negative, -0 and positive values.
        fill_relu_mix();
        expect_cols(COLS, 4'b1111, 1);
        pulse_start(4'b1111, 1);
        wait_done(200, 0, -1);

        // Channel mask 0101: followers 1 and 3 must stay idle.
        for (int ch = 0; ch < NCH; ch++) s0[ch] = start_cnt[ch];
        fill_random();
        expect_cols(COLS, 4'b0101, 0);
        pulse_start(4'b0101, 0);
        wait_done(200, 0, -1);
        chk("mask_start_ch0", start_cnt[0] - s0[0], 1);
        chk("mask_start_ch1", start_cnt[1] - s0[1], 0);
        chk("mask_start_ch2", start_cnt[2] - s0[2], 1);
        chk("mask_start_ch3", start_cnt[3] - s0[3], 0);

        // Full backpressure: only the first DEPTH columns survive.
        fill_random();
        en   = 4'($urandom());
        relu = 1'($urandom());
        expect_cols(DEPTH, en, relu);
        out_if.out_ready = 1'b0;
        pulse_start(en, relu);
        repeat (70) @(posedge clk);
        #1;
        chk("bp_overflow", overflow, 1);
        chk("bp_out_valid", out_if.out_valid, 1);
        chk("bp_head_idx", out_if.out_col_idx, 0);
        chk("bp_busy", busy, 1);
        out_if.out_ready = 1'b1;
        wait_done(100, 0, -1);
        chk("bp_sync_err", sync_err, 0);

        // Full FIFO held with a push pending, then simultaneous pop and push.
        fill_random();
        expect_cols(COLS, 4'b1111, 0);
        out_if.out_ready = 1'b0;
        pulse_start(4'b1111, 0);
        cyc       = 0;
        have_snap = 0;
        while (bram_addr != 5 && cyc < 60) begin
            if (out_if.out_valid && !have_snap) begin
                snap      = out_if.out_data;
                have_snap = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold_reach_col4", bram_addr, 5);
        chk("hold_seen_valid", have_snap, 1);
        chk_col("hold_out_data", out_if.out_data, snap);
        chk("hold_head_idx", out_if.out_col_idx, 0);
        chk("hold_overflow", overflow, 0);
        out_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("swap_head_idx", out_if.out_col_idx, 1);
        chk("swap_out_valid", out_if.out_valid, 1);
        chk("swap_overflow", overflow, 0);
        wait_done(200, 0, -1);
        chk("swap_overflow_end", overflow, 0);

        // Randomised images with jittered out_ready; one gets a stray start mid-run.
        for (int t = 0; t < 3; t++) begin
            for (int ch = 0; ch < NCH; ch++) s0[ch] = start_cnt[ch];
            fill_random();
            en   = 4'($urandom());
            relu = 1'($urandom());
            expect_cols(COLS, en, relu);
            pulse_start(en, relu);
            wait_done(200, 1, (t == 1) ? 20 : -1);
            chk("rand_overflow", overflow, 0);
            chk("rand_sync_err", sync_err, 0);
            chk("rand_start_ch0", start_cnt[0] - s0[0], 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
